// File: rtl/p2s_slave_mc_if.sv
// Bus bundle for the multi-lane parallel-to-serial slave: parallel capture
// inputs, master-driven serial controls and the slave's serial/status outputs.
interface p2s_slave_mc_if #(
  parameter int NBIT  = 64,
  parameter int NLANE = 1
);
  localparam int CW = ($clog2(NBIT + 1) < 1) ? 1 : $clog2(NBIT + 1);

  logic [NLANE*NBIT-1:0] pi;
  logic                  sld_n;
  logic                  sclk;
  logic [NLANE-1:0]      so;
  logic                  busy;
  logic                  frame_done;
  logic                  ovf;
  logic [CW-1:0]         bit_cnt;

  modport master (
    output pi, sld_n, sclk,
    input  so, busy, frame_done, ovf, bit_cnt
  );

  modport slave (
    input  pi, sld_n, sclk,
    output so, busy, frame_done, ovf, bit_cnt
  );
endinterface

// File: rtl/p2s_slave_mc.sv
// Multi-lane parallel-to-serial slave: captures a parallel word while sld_n is
// low, then presents one bit per lane on each qualified sclk edge, oversampled in clk.
module p2s_slave_mc #(
  parameter int NBIT      = 64,
  parameter int NLANE     = 1,
  parameter int SYNC_STG  = 3,
  parameter int SCLK_EDGE = 0,
  parameter int MSB_FIRST = 0
) (
  input logic           clk,
  input logic           rst,
  p2s_slave_mc_if.slave bus
);
  localparam int            CW   = ($clog2(NBIT + 1) < 1) ? 1 : $clog2(NBIT + 1);
  localparam int            IDX0 = (MSB_FIRST != 0) ? NBIT - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(NBIT);

  logic [SYNC_STG-1:0]   r_sclkSync;
  logic [SYNC_STG-1:0]   r_sldSync;
  logic                  r_sclkD;
  logic [NLANE*NBIT-1:0] r_shadow;
  logic [NLANE-1:0]      r_so;
  logic [CW-1:0]         r_bitCnt;
  logic                  r_ovf;
  logic                  r_frameDone;

  logic                  w_sclkS;
  logic                  w_loadActive;
  logic                  w_qualEdge;
  logic [CW-1:0]         w_idx;
  logic [NLANE-1:0]      w_loadSo;
  logic [NLANE-1:0]      w_shiftSo;

  // sld_n idles high, so its chain resets to 1 to avoid a phantom load after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclkSync <= '0;
      r_sldSync  <= '1;
      r_sclkD    <= 1'b0;
    end else begin
      r_sclkSync <= {r_sclkSync[SYNC_STG-2:0], bus.sclk};
      r_sldSync  <= {r_sldSync[SYNC_STG-2:0], bus.sld_n};
      r_sclkD    <= r_sclkSync[SYNC_STG-1];
    end
  end

  assign w_sclkS      = r_sclkSync[SYNC_STG-1];
  assign w_loadActive = ~r_sldSync[SYNC_STG-1];
  assign w_qualEdge   = (SCLK_EDGE == 0) ? (~w_sclkS & r_sclkD) : (w_sclkS & ~r_sclkD);

  // Index only meaningful while bit_cnt < NBIT; other values select nothing useful
  assign w_idx = (MSB_FIRST != 0) ? (LAST - CW'(1) - r_bitCnt) : r_bitCnt;

  always_comb begin
    w_loadSo  = '0;
    w_shiftSo = r_so;
    for (int k = 0; k < NLANE; k++) begin
      w_loadSo[k] = bus.pi[k*NBIT + IDX0];
      for (int b = 0; b < NBIT; b++) begin
        if (w_idx == CW'(b)) begin
          w_shiftSo[k] = r_shadow[k*NBIT + b];
        end
      end
    end
  end

  // Load dominates any coincident edge; it restarts the frame with fresh capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow    <= '0;
      r_so        <= '0;
      r_bitCnt    <= '0;
      r_ovf       <= 1'b0;
      r_frameDone <= 1'b0;
    end else if (w_loadActive) begin
      r_shadow    <= bus.pi;
      r_so        <= w_loadSo;
      r_bitCnt    <= CW'(1);
      r_ovf       <= 1'b0;
      r_frameDone <= 1'b0;
    end else begin
      r_frameDone <= 1'b0;
      if (w_qualEdge && (r_bitCnt != '0)) begin
        if (r_bitCnt < LAST) begin
          r_so        <= w_shiftSo;
          r_bitCnt    <= r_bitCnt + CW'(1);
          r_frameDone <= (r_bitCnt == (LAST - CW'(1)));
        end else begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  assign bus.so         = r_so;
  assign bus.bit_cnt    = r_bitCnt;
  assign bus.ovf        = r_ovf;
  assign bus.frame_done = r_frameDone;
  assign bus.busy       = (r_bitCnt != '0) && (r_bitCnt < LAST) && !w_loadActive;
endmodule

// File: tb/tb_p2s_slave_mc.sv
// Bench for p2s_slave_mc: two instances (2-lane LSB-first falling-edge, 1-lane
// MSB-first rising-edge) share one set of pins and are compared to a frame model.
module tb_p2s_slave_mc;
  localparam int NBIT = 8;
  localparam int SYNC = 3;
  localparam int HMIN = SYNC + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclkPin = 1'b1;
  logic        sldNPin = 1'b1;
  logic [15:0] piPin = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mShA;
  logic [1:0]  mSoA;
  int          mCntA;
  logic        mOvfA;
  int          mDoneA;
  logic [7:0]  mShB;
  logic        mSoB;
  int          mCntB;
  logic        mOvfB;
  int          mDoneB;
  int          obsDoneA = 0;
  int          obsDoneB = 0;

  int expA0 [8] = '{0, 1, 1, 1, 1, 0, 0, 0};
  int expA1 [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
  int expB  [8] = '{0, 0, 0, 1, 1, 1, 1, 0};

  p2s_slave_mc_if #(.NBIT(NBIT), .NLANE(2)) busA ();
  p2s_slave_mc_if #(.NBIT(NBIT), .NLANE(1)) busB ();

  assign busA.pi    = piPin;
  assign busA.sld_n = sldNPin;
  assign busA.sclk  = sclkPin;
  assign busB.pi    = piPin[7:0];
  assign busB.sld_n = sldNPin;
  assign busB.sclk  = sclkPin;

  p2s_slave_mc #(.NBIT(NBIT), .NLANE(2), .SYNC_STG(SYNC), .SCLK_EDGE(0), .MSB_FIRST(0)) dutA (
    .clk(clk), .rst(rst), .bus(busA.slave)
  );
  p2s_slave_mc #(.NBIT(NBIT), .NLANE(1), .SYNC_STG(SYNC), .SCLK_EDGE(1), .MSB_FIRST(1)) dutB (
    .clk(clk), .rst(rst), .bus(busB.slave)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Serial bit n of a lane, straight from the bit-order rule
  function automatic logic serialBit(input logic [15:0] sh, input int lane, input int n, input bit msb);
    int pos;
    pos = msb ? (NBIT - 1 - n) : n;
    return sh[lane*NBIT + pos];
  endfunction

  task automatic modelReset();
    mShA = '0; mSoA = '0; mCntA = 0; mOvfA = 1'b0;
    mShB = '0; mSoB = 1'b0; mCntB = 0; mOvfB = 1'b0;
  endtask

  task automatic modelLoad(input logic [15:0] p);
    mShA = p; mCntA = 1; mOvfA = 1'b0;
    mSoA[0] = serialBit(mShA, 0, 0, 1'b0);
    mSoA[1] = serialBit(mShA, 1, 0, 1'b0);
    mShB = p[7:0]; mCntB = 1; mOvfB = 1'b0;
    mSoB = serialBit({8'h00, mShB}, 0, 0, 1'b1);
  endtask

  task automatic modelShiftA();
    if (mCntA >= NBIT) mOvfA = 1'b1;
    else if (mCntA > 0) begin
      mSoA[0] = serialBit(mShA, 0, mCntA, 1'b0);
      mSoA[1] = serialBit(mShA, 1, mCntA, 1'b0);
      mCntA++;
      if (mCntA == NBIT) mDoneA++;
    end
  endtask

  task automatic modelShiftB();
    if (mCntB >= NBIT) mOvfB = 1'b1;
    else if (mCntB > 0) begin
      mSoB = serialBit({8'h00, mShB}, 0, mCntB, 1'b1);
      mCntB++;
      if (mCntB == NBIT) mDoneB++;
    end
  endtask

  task automatic modelPins(input logic prevSclk, input logic newSclk, input logic newSldN, input logic [15:0] newPi);
    if (!newSldN) modelLoad(newPi);
    else begin
      if (prevSclk && !newSclk) modelShiftA();
      if (!prevSclk && newSclk) modelShiftB();
    end
  endtask

  task automatic applyStimulus(input logic newSclk, input logic newSldN, input logic [15:0] newPi, input int hold);
    logic prevSclk;
    @(negedge clk);
    prevSclk = sclkPin;
    sclkPin  = newSclk;
    sldNPin  = newSldN;
    piPin    = newPi;
    modelPins(prevSclk, newSclk, newSldN, newPi);
    repeat (hold) @(negedge clk);
  endtask

  task automatic checkAll(input string tag);
    #1;
    checkOutput({tag, ".soA"},   busA.so, mSoA);
    checkOutput({tag, ".cntA"},  busA.bit_cnt, mCntA);
    checkOutput({tag, ".ovfA"},  busA.ovf, mOvfA);
    checkOutput({tag, ".busyA"}, busA.busy, (mCntA >= 1 && mCntA < NBIT && sldNPin));
    checkOutput({tag, ".doneA"}, obsDoneA, mDoneA);
    checkOutput({tag, ".soB"},   busB.so, mSoB);
    checkOutput({tag, ".cntB"},  busB.bit_cnt, mCntB);
    checkOutput({tag, ".ovfB"},  busB.ovf, mOvfB);
    checkOutput({tag, ".busyB"}, busB.busy, (mCntB >= 1 && mCntB < NBIT && sldNPin));
    checkOutput({tag, ".doneB"}, obsDoneB, mDoneB);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".soA"},   busA.so, 0);
    checkOutput({tag, ".cntA"},  busA.bit_cnt, 0);
    checkOutput({tag, ".busyA"}, busA.busy, 0);
    checkOutput({tag, ".fdA"},   busA.frame_done, 0);
    checkOutput({tag, ".ovfA"},  busA.ovf, 0);
    checkOutput({tag, ".soB"},   busB.so, 0);
    checkOutput({tag, ".cntB"},  busB.bit_cnt, 0);
    checkOutput({tag, ".fdB"},   busB.frame_done, 0);
  endtask

  function automatic int hRand();
    return int'($urandom_range(HMIN - 1, HMIN + 3));
  endfunction

  // frame_done must coincide with the last bit being presented
  always @(negedge clk) begin
    if (busA.frame_done === 1'b1) begin
      obsDoneA++;
      checkOutput("fdCntA", busA.bit_cnt, NBIT);
      checkOutput("fdSoA", busA.so, mSoA);
    end
    if (busB.frame_done === 1'b1) begin
      obsDoneB++;
      checkOutput("fdCntB", busB.bit_cnt, NBIT);
      checkOutput("fdSoB", busB.so, mSoB);
    end
  end

  initial begin
    logic [15:0] p;
    int          n;
    int          prevCnt;
    logic        prevSclk;

    modelReset();
    mDoneA = 0;
    mDoneB = 0;
    #12;
    checkResetValues("por");
    @(negedge clk);
    rst = 1'b0;
    repeat (HMIN + 2) @(negedge clk);
    checkAll("idle");

    // Directed frame 0xF0/0x1E with pi cleared after release
    applyStimulus(1'b1, 1'b0, 16'hF01E, HMIN);
    checkAll("load1");
    checkOutput("seqA0", busA.so[0], expA0[0]);
    checkOutput("seqA1", busA.so[1], expA1[0]);
    checkOutput("seqB", busB.so, expB[0]);
    applyStimulus(1'b1, 1'b1, 16'hF01E, HMIN);
    applyStimulus(1'b1, 1'b1, 16'h0000, HMIN);
    checkAll("piClr");
    for (int s = 1; s <= 8; s++) begin
      applyStimulus(1'b0, 1'b1, 16'h0000, HMIN);
      checkAll("dirFall");
      if (s < 8) begin
        checkOutput("seqA0", busA.so[0], expA0[s]);
        checkOutput("seqA1", busA.so[1], expA1[s]);
        checkOutput("seqCntA", busA.bit_cnt, s + 1);
      end else begin
        checkOutput("ovfSetA", busA.ovf, 1);
        checkOutput("ovfHoldA", busA.so[0], expA0[7]);
        checkOutput("ovfCntA", busA.bit_cnt, NBIT);
      end
      applyStimulus(1'b1, 1'b1, 16'h0000, HMIN);
      checkAll("dirRise");
      if (s < 8) checkOutput("seqB", busB.so, expB[s]);
      else checkOutput("ovfSetB", busB.ovf, 1);
    end
    checkOutput("doneOnceA", obsDoneA, 1);

    // Fresh load clears overrun
    applyStimulus(1'b1, 1'b0, 16'h0FF0, HMIN);
    checkAll("ovfClr");
    checkOutput("ovfClrA", busA.ovf, 0);
    applyStimulus(1'b1, 1'b1, 16'h0FF0, HMIN);
    checkAll("rel2");

    // Pin-to-output latency on a falling sclk
    prevCnt = mCntA;
    @(negedge clk);
    prevSclk = sclkPin;
    sclkPin = 1'b0;
    modelPins(prevSclk, 1'b0, 1'b1, piPin);
    repeat (SYNC) @(negedge clk);
    checkOutput("latEarly", busA.bit_cnt, prevCnt);
    @(negedge clk);
    checkOutput("latOnTime", busA.bit_cnt, mCntA);
    repeat (2) @(negedge clk);
    checkAll("lat");
    applyStimulus(1'b1, 1'b1, piPin, HMIN);
    checkAll("latRise");

    // Abort: three cycles then reload with all ones
    applyStimulus(1'b0, 1'b1, piPin, HMIN);
    applyStimulus(1'b1, 1'b1, piPin, HMIN);
    applyStimulus(1'b0, 1'b1, piPin, HMIN);
    applyStimulus(1'b1, 1'b0, 16'hFFFF, HMIN);
    checkAll("abort");
    checkOutput("abortCntA", busA.bit_cnt, 1);
    checkOutput("abortSoA", busA.so, 2'b11);
    applyStimulus(1'b1, 1'b1, 16'hFFFF, HMIN);
    checkAll("abortRel");

    // Load coincident with a falling sclk: the edge is discarded
    applyStimulus(1'b0, 1'b0, 16'hA55A, HMIN);
    checkAll("simul");
    checkOutput("simulCntA", busA.bit_cnt, 1);
    applyStimulus(1'b0, 1'b1, 16'hA55A, HMIN);
    checkAll("simulRel");
    for (int c = 0; c < 3; c++) begin
      applyStimulus(~sclkPin, 1'b1, 16'hA55A, HMIN);
      checkAll("simulEdge");
    end

    // Asynchronous reset mid-frame
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkResetValues("rstMid");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (HMIN) @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(~sclkPin, 1'b1, 16'($urandom), HMIN);
      checkAll("noLoad");
    end
    checkOutput("noLoadCntA", busA.bit_cnt, 0);

    // Full frames at the minimum sclk half-period
    for (int f = 0; f < 2; f++) begin
      p = 16'($urandom);
      applyStimulus(sclkPin, 1'b0, p, HMIN - 1);
      checkAll("minLoad");
      applyStimulus(sclkPin, 1'b1, p, HMIN - 1);
      for (int c = 0; c < 2 * NBIT; c++) begin
        applyStimulus(~sclkPin, 1'b1, p, HMIN - 1);
        checkAll("minEdge");
      end
    end

    // Random frames, random lengths (some overrun), random hold times
    for (int f = 0; f < 14; f++) begin
      p = 16'($urandom);
      applyStimulus(sclkPin, 1'b0, p, hRand());
      checkAll("rLoad");
      applyStimulus(sclkPin, 1'b1, p, hRand());
      checkAll("rRel");
      n = int'($urandom_range(0, 20));
      for (int c = 0; c < n; c++) begin
        applyStimulus(~sclkPin, 1'b1, 16'($urandom), hRand());
        checkAll("rEdge");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
